// File: rtl/mac_accumulator_pkg.sv
// Purpose : shared state encoding and default widths for the MAC accumulator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package mac_accumulator_pkg;

    // Default product width: output of the upstream 4x4 multiplier.
    localparam int DEF_PROD_W = 8;
    // Default accumulator width: 15 * 225 = 3375 fits in 12 bits unsigned.
    localparam int DEF_ACC_W  = 12;

    // FSM encoding, kept as plain constants so older tools and tables can reuse it.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/mac_accumulator.sv
// Purpose : sums a run of 'len' unsigned products into acc_out, then holds the result.
// Latency : out_valid rises the cycle after the edge that accepts the last product.
// Backpressure: in_ready only in ACC; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start, len          - begin a run of len products (sampled only in IDLE)
//   product, in_valid   - product stream from the multiplier
//   in_ready            - high while collecting products
//   acc_out, out_valid  - accumulated sum / result is finished
//   out_ready           - downstream takes the result
//   busy                - high while a run is collecting or holding its result
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        len,
    input  logic [PROD_W-1:0] product,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    logic [1:0]       state;
    logic [ACC_W-1:0] acc;
    logic [3:0]       cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc   <= '0;
                        cnt   <= len;
                        // A zero-length run has nothing to collect; report 0 directly.
                        state <= (len != 4'd0) ? ST_ACC : ST_DONE;
                    end
                end
                ST_ACC: begin
                    // in_ready is implied by being in ACC, so in_valid alone means accept.
                    if (in_valid) begin
                        acc <= acc + ACC_W'(product);
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake outputs decode registered state only: no input-to-output paths.
    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state == ST_ACC) || (state == ST_DONE);
    assign acc_out   = acc;

endmodule

// File: tb/tb_mac_accumulator.sv
// Purpose : self-checking bench for mac_accumulator with directed runs.
// Latency : checks outputs every falling edge against a sum-of-products model.
// Backpressure: exercises input bubbles and held results with out_ready low.
module tb_mac_accumulator;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  len;
    logic [7:0]  product;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] acc_out;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks = 0;
    int errors = 0;

    mac_accumulator #(.PROD_W(8), .ACC_W(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .product   (product),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: a run is "collecting" while products are still owed,
    // "holding" once all have arrived, otherwise idle. The expected result is
    // simply the running sum of every product handed over during the run.
    int m_phase;   // 0 idle, 1 collecting, 2 holding
    int m_sum;
    int m_left;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_sum   = 0;
            m_left  = 0;
        end else begin
            if (m_phase == 0) begin
                if (start) begin
                    m_sum   = 0;
                    m_left  = int'(len);
                    m_phase = (len == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (in_valid) begin
                    m_sum  = m_sum + int'(product);
                    m_left = m_left - 1;
                    if (m_left == 0) m_phase = 2;
                end
            end else begin
                if (out_ready) m_phase = 0;
            end
        end
    end

    // Per-cycle comparison against the model, sampled away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready",  int'(in_ready),  (m_phase == 1) ? 1 : 0);
            chk("out_valid", int'(out_valid), (m_phase == 2) ? 1 : 0);
            chk("busy",      int'(busy),      (m_phase != 0) ? 1 : 0);
            chk("acc_out",   int'(acc_out),   m_sum % 4096);
        end
    end

    task automatic start_run(input logic [3:0] l);
        @(negedge clk);
        start = 1'b1;
        len   = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Present one product for exactly one cycle.
    task automatic push(input logic [7:0] p);
        in_valid = 1'b1;
        product  = p;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = 4'd0;
        product   = 8'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        #12;
        chk("reset acc_out",   int'(acc_out),   0);
        chk("reset out_valid", int'(out_valid), 0);
        chk("reset in_ready",  int'(in_ready),  0);
        chk("reset busy",      int'(busy),      0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic run: 15 + 30 + 225 on consecutive cycles.
        start_run(4'd3);
        push(8'd15);
        push(8'd30);
        push(8'd225);
        // This is the cycle after the edge that took the last product.
        chk("basic out_valid", int'(out_valid), 1);
        chk("basic acc_out",   int'(acc_out),   270);
        chk("model basic sum", m_sum,           270);
        consume();

        // Maximum run: 15 x 225 must not wrap.
        start_run(4'd15);
        for (int i = 0; i < 15; i++) push(8'd225);
        chk("max acc_out",   int'(acc_out), 3375);
        chk("max out_valid", int'(out_valid), 1);
        consume();

        // Zero-length run goes straight to a zero result.
        start_run(4'd0);
        chk("zero out_valid", int'(out_valid), 1);
        chk("zero acc_out",   int'(acc_out),   0);
        chk("zero in_ready",  int'(in_ready),  0);
        consume();

        // Bubbles: 9, three idle cycles, then 4.
        start_run(4'd2);
        push(8'd9);
        repeat (3) begin
            chk("bubble hold", int'(acc_out), 9);
            @(negedge clk);
        end
        push(8'd4);
        chk("bubble acc_out", int'(acc_out), 13);
        // Result held with out_ready low; a start pulse here must be ignored.
        for (int i = 0; i < 5; i++) begin
            chk("held out_valid", int'(out_valid), 1);
            chk("held acc_out",   int'(acc_out),   13);
            start = (i == 2);
            len   = 4'd7;
            @(negedge clk);
        end
        start = 1'b0;
        chk("held after start", int'(acc_out), 13);
        consume();
        // Back in IDLE the last result stays visible.
        chk("idle hold acc_out", int'(acc_out), 13);

        // Back-to-back run: start right after returning to IDLE, single product 1.
        start_run(4'd1);
        push(8'd1);
        chk("b2b acc_out",   int'(acc_out),   1);
        chk("b2b out_valid", int'(out_valid), 1);
        consume();

        // Reset mid-run after two products.
        start_run(4'd5);
        push(8'd3);
        push(8'd4);
        chk("pre-reset acc_out", int'(acc_out), 7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset acc_out",   int'(acc_out),   0);
        chk("async reset out_valid", int'(out_valid), 0);
        chk("async reset in_ready",  int'(in_ready),  0);
        chk("async reset busy",      int'(busy),      0);
        // Start is already high when reset releases; the next edge honours it.
        start = 1'b1;
        len   = 4'd1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post-reset in_ready", int'(in_ready), 1);
        push(8'd7);
        chk("post-reset acc_out", int'(acc_out), 7);
        consume();
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
